serial_subtractor: RTL and testbench

- Bit-serial unsigned/two's-complement subtractor: computes diff = in_a - in_b, LSB first, one bit per clock.
- Datapath is one half/full-subtractor cell plus a borrow flip-flop, sequenced by a small FSM with a start/busy/done handshake.
- Counterpart to the combinational adder cells. Serves area-constrained arithmetic paths in the exercise series and acts as a sequential reference against behavioural subtraction.

---
 rtl/serial_subtractor.sv | 150 +++++++++++++++
 tb/tb_serial_subtractor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor: diff = in_a - in_b (mod 2^WIDTH), one bit per
//   clock, LSB first. A single full-subtractor cell and a borrow flop are
//   sequenced by an IDLE -> SHIFT -> DONE FSM with a start/busy/done
//   handshake. Results are registered and held until the next completion.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       operation request, honoured only in IDLE or DONE
//   in_a, in_b  minuend / subtrahend, captured on the accepting edge
//   busy        high while the FSM is stepping bits (SHIFT)
//   done        one-cycle pulse: diff/borrow_out/overflow just updated
//   diff        (in_a - in_b) mod 2^WIDTH
//   borrow_out  final borrow (in_a < in_b, unsigned)
//   overflow    signed overflow of in_a - in_b
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic a0, b0, step_d, step_bo, accept, last_step;

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    diff_d       = diff_q;
    cnt_d        = cnt_q;
    brw_d        = brw_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;
    done_d       = 1'b0;

    // Full-subtractor cell on the current LSBs and the running borrow.
    a0        = a_sh_q[0];
    b0        = b_sh_q[0];
    step_d    = a0 ^ b0 ^ brw_q;
    step_bo   = (~a0 & b0) | (~(a0 ^ b0) & brw_q);
    accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    last_step = (cnt_q == CW'(WIDTH - 1));

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE is a one-cycle state; a start here chains straight into
        // the next operation without passing through IDLE.
        state_d = S_IDLE;
        if (accept) begin
          a_sh_d  = in_a;
          b_sh_d  = in_b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          a_msb_d = in_a[WIDTH-1];
          b_msb_d = in_b[WIDTH-1];
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {step_d, res_q[WIDTH-1:1]};
        brw_d  = step_bo;
        cnt_d  = cnt_q + CW'(1);
        if (last_step) begin
          diff_d       = res_d;
          borrow_out_d = step_bo;
          // Signed overflow: operand signs differ and the result sign
          // (the bit produced this step) disagrees with the minuend.
          overflow_d   = (a_msb_q != b_msb_q) && (step_d != a_msb_q);
          done_d       = 1'b1;
          state_d      = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      brw_q        <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      diff_q       <= diff_d;
      cnt_q        <= cnt_d;
      brw_q        <= brw_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
    end
  end

  assign busy       = (state_q == S_SHIFT);
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH = 8 instance
  logic        start8 = 1'b0;
  logic [7:0]  in_a8 = '0, in_b8 = '0;
  logic        busy8, done8, bo8, ov8;
  logic [7:0]  diff8;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .in_a(in_a8), .in_b(in_b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8),
    .overflow(ov8)
  );

  // WIDTH = 13 instance
  logic        start13 = 1'b0;
  logic [12:0] in_a13 = '0, in_b13 = '0;
  logic        busy13, done13, bo13, ov13;
  logic [12:0] diff13;

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .in_a(in_a13), .in_b(in_b13),
    .busy(busy13), .done(done13), .diff(diff13), .borrow_out(bo13),
    .overflow(ov13)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge. Returns at the negedge where done is seen.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         output int edges, output int busy_n, output bit ok);
    start8 = 1'b1; in_a8 = a; in_b8 = b;
    @(negedge clk);
    start8 = 1'b0; in_a8 = '0; in_b8 = '0;
    edges = 0; busy_n = 0; ok = 1'b0;
    while (edges < 40) begin
      if (done8) begin ok = 1'b1; break; end
      if (busy8) busy_n++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run_op13(input logic [12:0] a, input logic [12:0] b,
                          output bit ok);
    int n;
    start13 = 1'b1; in_a13 = a; in_b13 = b;
    @(negedge clk);
    start13 = 1'b0; in_a13 = '0; in_b13 = '0;
    n = 0; ok = 1'b0;
    while (n < 40) begin
      if (done13) begin ok = 1'b1; break; end
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  vec_t vec[7];

  initial begin
    int edges, busy_n, pulses, late_busy, t1, t2, n;
    bit ok, seen;
    logic [7:0] cap_d;
    logic cap_bo;

    vec[0] = '{8'd100, 8'd58, 8'd42,  1'b0, 1'b0};
    vec[1] = '{8'h05,  8'h09, 8'hFC,  1'b1, 1'b0};
    vec[2] = '{8'hFF,  8'hFF, 8'h00,  1'b0, 1'b0};
    vec[3] = '{8'h80,  8'h01, 8'h7F,  1'b0, 1'b1};
    vec[4] = '{8'h7F,  8'hFF, 8'h80,  1'b1, 1'b1};
    vec[5] = '{8'h00,  8'h01, 8'hFF,  1'b1, 1'b0};
    vec[6] = '{8'h81,  8'h7F, 8'h02,  1'b0, 1'b1};

    // Reset state
    #12;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_bo",   bo8,   0);
    chk("rst_ov",   ov8,   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_op8(vec[i].a, vec[i].b, edges, busy_n, ok);
      chk($sformatf("v%0d_done_seen", i), ok, 1);
      chk($sformatf("v%0d_latency", i), edges, 8);
      chk($sformatf("v%0d_busy_cycles", i), busy_n, 8);
      chk($sformatf("v%0d_busy_in_done", i), busy8, 0);
      chk($sformatf("v%0d_diff", i), diff8, vec[i].d);
      chk($sformatf("v%0d_borrow", i), bo8, vec[i].bo);
      chk($sformatf("v%0d_ovf", i), ov8, vec[i].ov);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse1", i), done8, 0);
      chk($sformatf("v%0d_diff_hold", i), diff8, vec[i].d);
    end

    // Start pulsed while busy is ignored
    start8 = 1'b1; in_a8 = 8'h30; in_b8 = 8'h10;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1; in_a8 = 8'h01; in_b8 = 8'h02;
    @(negedge clk); start8 = 1'b0;
    pulses = 0; late_busy = 0; seen = 1'b0; cap_d = '0;
    for (int k = 0; k < 25; k++) begin
      if (done8) begin pulses++; cap_d = diff8; seen = 1'b1; end
      else if (seen && busy8) late_busy++;
      @(negedge clk);
    end
    chk("busy_start_pulses", pulses, 1);
    chk("busy_start_diff", cap_d, 8'h20);
    chk("busy_start_no_second_op", late_busy, 0);

    // Back-to-back with start held high
    start8 = 1'b1; in_a8 = 8'h10; in_b8 = 8'h01;
    @(negedge clk);
    n = 0;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    t1 = cyc;
    chk("b2b_first_done", done8, 1);
    chk("b2b_first_diff", diff8, 8'h0F);
    in_a8 = 8'h00; in_b8 = 8'h01;
    @(negedge clk);
    n = 0;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    t2 = cyc;
    start8 = 1'b0;
    chk("b2b_second_done", done8, 1);
    chk("b2b_spacing", t2 - t1, 9);
    chk("b2b_second_diff", diff8, 8'hFF);
    chk("b2b_second_borrow", bo8, 1);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_idle_after", busy8, 0);

    // Asynchronous reset mid-SHIFT
    start8 = 1'b1; in_a8 = 8'h55; in_b8 = 8'h22;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy8, 0);
    chk("arst_done", done8, 0);
    chk("arst_diff", diff8, 0);
    chk("arst_bo",   bo8,   0);
    chk("arst_ov",   ov8,   0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done8 || busy8) pulses++;
    end
    chk("arst_no_activity", pulses, 0);
    run_op8(8'h55, 8'h22, edges, busy_n, ok);
    chk("arst_next_done", ok, 1);
    chk("arst_next_diff", diff8, 8'h33);
    @(negedge clk);

    // Random sweep, WIDTH = 8
    for (int k = 0; k < 1500; k++) begin
      logic [7:0] a, b, e;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      e = a - b;
      run_op8(a, b, edges, busy_n, ok);
      chk("rnd8_done", ok, 1);
      chk("rnd8_diff", diff8, e);
      chk("rnd8_borrow", bo8, (a < b));
      chk("rnd8_ovf", ov8, (a[7] != b[7]) && (e[7] != a[7]));
      @(negedge clk);
    end

    // Random sweep, WIDTH = 13
    for (int k = 0; k < 1500; k++) begin
      logic [12:0] a, b, e;
      a = 13'($urandom_range(0, 8191));
      b = 13'($urandom_range(0, 8191));
      e = a - b;
      run_op13(a, b, ok);
      chk("rnd13_done", ok, 1);
      chk("rnd13_diff", diff13, e);
      chk("rnd13_borrow", bo13, (a < b));
      chk("rnd13_ovf", ov13, (a[12] != b[12]) && (e[12] != a[12]));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
